timer_irq_source: RTL and testbench

//  Memory-mapped countdown timer that raises a hardware interrupt line into the CPU's HWInt vector (wired to HWInt[2]).

---
 rtl/timer_irq_source.sv | 67 ++++++
 tb/tb_timer_irq_source.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped countdown timer raising HWInt[2]; define TIMER_PRESCALE_EN to add the PRESCALE register
module timer_irq_source #(
  parameter int COUNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        int_ack,
  output logic        irq
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3;
  logic [1:0] state;
  logic [3:0] ctrl;
  logic [COUNT_W-1:0] preset, count;
  logic [PSC_W-1:0] prescale;
  logic pend, tick, ctrl_wr, zero_hit;
  assign ctrl_wr = we && addr == 2'd0;
  assign zero_hit = state == CNT && ctrl[0] && tick && count == '0;
  assign irq = pend & ctrl[3];
  assign rdata = addr == 2'd0 ? {28'd0, ctrl} : addr == 2'd1 ? 32'(preset) : addr == 2'd2 ? 32'(count) : 32'(prescale);
`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc;
  assign tick = psc == prescale;
  always_ff @(posedge clk)
    if (!reset) begin
      prescale <= '0;
      psc <= '0;
    end else begin
      if (we && addr == 2'd3) prescale <= wdata[PSC_W-1:0];
      psc <= state == LOAD ? '0 : state == CNT ? (tick ? '0 : psc + 1'b1) : psc;
    end
`else
  assign prescale = '0;
  assign tick = 1'b1;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      ctrl <= '0;
      preset <= '0;
      count <= '0;
      pend <= 1'b0;
    end else begin
      if (we && addr == 2'd1) preset <= wdata[COUNT_W-1:0];
      case (state)
        IDLE: if (ctrl[0]) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: if (!ctrl[0]) state <= IDLE;
          else if (tick && count != '0) count <= count - 1'b1;
          else if (tick) state <= INT;
        default: begin
          state <= ctrl[2:1] == 2'b01 ? LOAD : IDLE;
          if (ctrl[2:1] != 2'b01) ctrl[0] <= 1'b0;
        end
      endcase
      // a CTRL write lands after the FSM so its EN beats the one-shot auto-clear
      if (ctrl_wr) ctrl <= wdata[3:0];
      pend <= zero_hit | (pend & ~ctrl_wr & ~int_ack);
    end
endmodule

// File: tb/tb_timer_irq_source.sv
// tb_timer_irq_source: scoreboard bench for timer_irq_source
module tb_timer_irq_source;
  logic clk = 1'b0, reset = 1'b0, we = 1'b0, int_ack = 1'b0, irq;
  logic [1:0] addr = 2'd0;
  logic [31:0] wdata = '0, rdata, v;
  int n_chk = 0, n_fail = 0;
  typedef struct {string name; logic [31:0] val;} exp_t;
  exp_t sb[$];
  exp_t e;

  timer_irq_source dut (.clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
                        .rdata(rdata), .int_ack(int_ack), .irq(irq));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    addr = a;
    #1;
    r = rdata;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    for (int a = 0; a < 4; a++) sb.push_back('{$sformatf("reset_rd%0d", a), 32'd0});
    sb.push_back('{"reset_irq", 32'd0});
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      e = sb.pop_front(); n_chk++;
      if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
    end
    e = sb.pop_front(); n_chk++;
    if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
    reset = 1'b1;
    wr(2'd2, 32'h55);
    sb.push_back('{"count_read_only", 32'd0});
    rd(2'd2, v);
    e = sb.pop_front(); n_chk++;
    if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
  endtask

  task automatic test_one_shot();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 8; i++) sb.push_back('{$sformatf("oneshot_irq_e%0d", i), 32'(i == 8)});
    for (int i = 1; i <= 8; i++) begin
      step();
      e = sb.pop_front(); n_chk++;
      if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
    end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    sb.push_back('{"oneshot_ack_irq", 32'd0});
    sb.push_back('{"oneshot_count", 32'd0});
    sb.push_back('{"oneshot_ctrl", 32'h8});
    e = sb.pop_front(); n_chk++;
    if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
    for (int a = 2; a >= 0; a -= 2) begin
      rd(2'(a), v);
      e = sb.pop_front(); n_chk++;
      if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
    end
  endtask

  task automatic test_auto_reload();
    int pulses = 0;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int i = 1; i <= 20; i++) sb.push_back('{$sformatf("reload_irq_e%0d", i), 32'(i % 5 == 0)});
    for (int i = 1; i <= 20; i++) begin
      step();
      e = sb.pop_front(); n_chk++;
      if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
      pulses += irq ? 1 : 0;
      int_ack = irq;
    end
    sb.push_back('{"reload_pulses", 32'd4});
    e = sb.pop_front(); n_chk++;
    if (32'(pulses) !== e.val) begin n_fail++; $display("FAIL %s: got %0d required %0d", e.name, pulses, e.val); end
    sb.push_back('{"reload_ctrl_en_kept", 32'hB});
    rd(2'd0, v);
    e = sb.pop_front(); n_chk++;
    if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
    wr(2'd0, 32'h0);
    int_ack = 1'b0;
    repeat (3) step();
    sb.push_back('{"reload_stopped_irq", 32'd0});
    e = sb.pop_front(); n_chk++;
    if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
  endtask

  task automatic test_zero_preset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 9; i++) sb.push_back('{$sformatf("zero_irq_e%0d", i), 32'(i >= 3)});
    for (int i = 1; i <= 9; i++) begin
      step();
      e = sb.pop_front(); n_chk++;
      if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
    end
    wr(2'd0, 32'h0);
    sb.push_back('{"zero_ctrl_clear_irq", 32'd0});
    e = sb.pop_front(); n_chk++;
    if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
    repeat (2) step();
    sb.push_back('{"zero_idle_count", 32'd0});
    rd(2'd2, v);
    e = sb.pop_front(); n_chk++;
    if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
  endtask

  task automatic test_priority();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 3; i++) sb.push_back('{$sformatf("prio_irq_e%0d", i), 32'd0});
    sb.push_back('{"prio_set_beats_clears", 32'd1});
    for (int i = 1; i <= 3; i++) begin
      step();
      e = sb.pop_front(); n_chk++;
      if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
    end
    int_ack = 1'b1; addr = 2'd0; wdata = 32'h9; we = 1'b1;
    step();
    int_ack = 1'b0; we = 1'b0;
    e = sb.pop_front(); n_chk++;
    if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
    wr(2'd0, 32'h9);
    sb.push_back('{"prio_int_write_irq", 32'd0});
    sb.push_back('{"prio_int_write_en_wins", 32'h9});
    e = sb.pop_front(); n_chk++;
    if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
    rd(2'd0, v);
    e = sb.pop_front(); n_chk++;
    if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
    wr(2'd0, 32'h0);
    repeat (4) step();
  endtask

  task automatic test_masked();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    wr(2'd0, 32'h1);
    for (int i = 2; i <= 7; i++) sb.push_back('{$sformatf("masked_irq_e%0d", i), 32'd0});
    sb.push_back('{"masked_count", 32'd0});
    for (int i = 2; i <= 7; i++) begin
      step();
      e = sb.pop_front(); n_chk++;
      if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
    end
    rd(2'd2, v);
    e = sb.pop_front(); n_chk++;
    if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
    wr(2'd0, 32'h8);
    for (int i = 0; i < 3; i++) sb.push_back('{$sformatf("masked_cleared_irq%0d", i), 32'd0});
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front(); n_chk++;
      if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
      step();
    end
    sb.push_back('{"masked_ctrl", 32'h8});
    rd(2'd0, v);
    e = sb.pop_front(); n_chk++;
    if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
  endtask

  task automatic test_reset_mid();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (9) step();
    sb.push_back('{"mid_count_before", 32'd3});
    rd(2'd2, v);
    e = sb.pop_front(); n_chk++;
    if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    sb.push_back('{"mid_reset_ctrl", 32'd0});
    sb.push_back('{"mid_reset_preset", 32'd0});
    sb.push_back('{"mid_reset_count", 32'd0});
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      e = sb.pop_front(); n_chk++;
      if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
    end
    sb.push_back('{"mid_reset_irq", 32'd0});
    e = sb.pop_front(); n_chk++;
    if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
  endtask

  task automatic test_prescale();
`ifdef TIMER_PRESCALE_EN
    wr(2'd3, 32'd3);
    sb.push_back('{"psc_readback", 32'd3});
    rd(2'd3, v);
    e = sb.pop_front(); n_chk++;
    if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
    wr(2'd1, 32'd1);
    wr(2'd0, 32'hB);
    for (int i = 1; i <= 30; i++) sb.push_back('{$sformatf("psc_irq_e%0d", i), 32'(i % 10 == 0)});
    for (int i = 1; i <= 30; i++) begin
      step();
      e = sb.pop_front(); n_chk++;
      if ({31'd0, irq} !== e.val) begin n_fail++; $display("FAIL %s: got %b required 0x%0h", e.name, irq, e.val); end
      int_ack = irq;
    end
    wr(2'd0, 32'h0);
    int_ack = 1'b0;
`else
    wr(2'd3, 32'hFF);
    sb.push_back('{"psc_absent_reads_zero", 32'd0});
    rd(2'd3, v);
    e = sb.pop_front(); n_chk++;
    if (v !== e.val) begin n_fail++; $display("FAIL %s: got 0x%0h required 0x%0h", e.name, v, e.val); end
`endif
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_zero_preset();
    test_priority();
    test_masked();
    test_reset_mid();
    test_prescale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
